// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory and the control decoder.
// Access-type encodings and default memory depth.
package data_memory_pkg;

  localparam logic [2:0] MEMOP_W  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_HU = 3'b010;
  localparam logic [2:0] MEMOP_B  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;

  localparam int DM_DEPTH_WORDS = 3072;

  function automatic logic memop_reserved(input logic [2:0] op);
    return op > MEMOP_BU;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane merge for stores and sign/zero extension for loads.
// Purely combinational; operates on one 32-bit word.
module dm_lane_unit
  import data_memory_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  mem_op,
  input  logic [31:0] wdata,
  output logic [31:0] wr_word,
  output logic [31:0] rd_word
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    wr_word = old_word;
    rd_word = '0;
    half    = byte_off[1] ? old_word[31:16]
                          : old_word[15:0];
    byte_v  = old_word[{byte_off, 3'b000} +: 8];
    case (mem_op)
      MEMOP_W: begin
        wr_word = wdata;
        rd_word = old_word;
      end
      MEMOP_H, MEMOP_HU: begin
        if (byte_off[1])
          wr_word[31:16] = wdata[15:0];
        else
          wr_word[15:0] = wdata[15:0];
        if (mem_op == MEMOP_H)
          rd_word = {{16{half[15]}}, half};
        else
          rd_word = {16'h0000, half};
      end
      MEMOP_B, MEMOP_BU: begin
        wr_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
        if (mem_op == MEMOP_B)
          rd_word = {{24{byte_v[7]}}, byte_v};
        else
          rd_word = {24'h000000, byte_v};
      end
      default: begin
        wr_word = old_word;
        rd_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory: byte-lane stores on the clock edge,
// combinational extended loads, alignment/range checking, store log.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int AW          = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   merged_d;
  logic [31:0]   ld_word;
  logic          misalign;
  logic          we_d;

  always_comb begin
    idx      = addr[AW+1:2];
    misalign = 1'b0;
    case (mem_op)
      MEMOP_W:           misalign = addr[1:0] != 2'b00;
      MEMOP_H, MEMOP_HU: misalign = addr[0];
      default:           misalign = 1'b0;
    endcase
    addr_err = misalign
             | (addr >= LIMIT)
             | memop_reserved(mem_op);
    // idx may exceed the array when out of range; never read it then
    old_word = addr_err ? 32'h0 : mem_q[idx];
    rdata    = addr_err ? 32'h0 : ld_word;
    we_d     = mem_write & ~addr_err;
  end

  dm_lane_unit u_lane (
    .old_word (old_word),
    .byte_off (addr[1:0]),
    .mem_op   (mem_op),
    .wdata    (wdata),
    .wr_word  (merged_d),
    .rd_word  (ld_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem_q[i] <= '0;
    end else if (we_d) begin
      mem_q[idx] <= merged_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && we_d)
      $display("@%h: *%h <= %h", pc,
               {addr[31:2], 2'b00}, merged_d);
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with an expected-result queue.
// Loads and error flags are checked against values the bench derives.
module tb_data_memory;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_RS = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [2:0]  mem_op;
  logic [31:0] rdata;
  logic        addr_err;

  typedef struct {
    string       tag;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_memory dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_op    (mem_op),
    .rdata     (rdata),
    .addr_err  (addr_err)
  );

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard empty");
      return;
    end
    e = sb_q.pop_front();
    total++;
    assert (addr_err === e.err) else begin
      bad++;
      $error("FAIL %s addr_err got=%b exp=%b",
             e.tag, addr_err, e.err);
    end
    if (e.chk_rd) begin
      total++;
      assert (rdata === e.rd) else begin
        bad++;
        $error("FAIL %s rdata got=%h exp=%h",
               e.tag, rdata, e.rd);
      end
    end
  endtask

  task automatic load(input string tag,
                      input logic [31:0] a,
                      input logic [2:0] op,
                      input logic [31:0] exp_rd,
                      input logic exp_err);
    @(negedge clk);
    mem_write = 1'b0;
    addr      = a;
    mem_op    = op;
    sb_q.push_back('{tag, 1'b1, exp_rd, exp_err});
    #1;
    compare();
  endtask

  task automatic store(input string tag,
                       input logic [31:0] a,
                       input logic [2:0] op,
                       input logic [31:0] d,
                       input logic exp_err);
    @(negedge clk);
    pc        = pc + 32'd4;
    addr      = a;
    mem_op    = op;
    wdata     = d;
    mem_write = 1'b1;
    sb_q.push_back('{tag, 1'b0, 32'h0, exp_err});
    #1;
    compare();
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    pc        = 32'h0000_1000;
    addr      = '0;
    wdata     = '0;
    mem_write = 1'b0;
    mem_op    = OP_W;

    load("rst_lw0", 32'h0, OP_W, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 1: reset mid-run wipes memory; store during reset dropped
    store("sw0", 32'h0, OP_W, 32'h1234_5678, 1'b0);
    load("lw0", 32'h0, OP_W, 32'h1234_5678, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    load("lw0_inrst", 32'h0, OP_W, 32'h0, 1'b0);
    store("sw_inrst", 32'h0, OP_W, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    load("lw0_after", 32'h0, OP_W, 32'h0, 1'b0);

    // 2: extensions
    store("sw10", 32'h10, OP_W, 32'h80FF_7F01, 1'b0);
    load("lb10",  32'h10, OP_B,  32'h0000_0001, 1'b0);
    load("lb13",  32'h13, OP_B,  32'hFFFF_FF80, 1'b0);
    load("lbu13", 32'h13, OP_BU, 32'h0000_0080, 1'b0);
    load("lh12",  32'h12, OP_H,  32'hFFFF_80FF, 1'b0);
    load("lhu12", 32'h12, OP_HU, 32'h0000_80FF, 1'b0);
    load("lh10",  32'h10, OP_H,  32'h0000_7F01, 1'b0);
    load("lb11",  32'h11, OP_B,  32'h0000_007F, 1'b0);

    // 3: lane merges compose
    store("sw20", 32'h20, OP_W, 32'h0, 1'b0);
    store("sb20", 32'h20, OP_B, 32'h1234_56AA, 1'b0);
    store("sb23", 32'h23, OP_BU, 32'h0000_00BB, 1'b0);
    load("lw20a", 32'h20, OP_W, 32'hBB00_00AA, 1'b0);
    store("sh22", 32'h22, OP_H, 32'h9999_CCDD, 1'b0);
    load("lw20b", 32'h20, OP_W, 32'hCCDD_00AA, 1'b0);
    store("sh20", 32'h20, OP_HU, 32'h0000_1357, 1'b0);
    load("lw20c", 32'h20, OP_W, 32'hCCDD_1357, 1'b0);

    // 4: misaligned / out of range
    store("sw4", 32'h4, OP_W, 32'hA5A5_A5A5, 1'b0);
    store("sw6", 32'h6, OP_W, 32'hFFFF_FFFF, 1'b1);
    load("lw4", 32'h4, OP_W, 32'hA5A5_A5A5, 1'b0);
    store("sh5", 32'h5, OP_H, 32'hFFFF_FFFF, 1'b1);
    load("lw4b", 32'h4, OP_W, 32'hA5A5_A5A5, 1'b0);
    store("swtop", 32'h2FFC, OP_W, 32'hCAFE_F00D, 1'b0);
    store("sw3000", 32'h3000, OP_W, 32'h1111_2222, 1'b1);
    load("lwtop", 32'h2FFC, OP_W, 32'hCAFE_F00D, 1'b0);
    load("lbtop", 32'h2FFF, OP_BU, 32'h0000_00CA, 1'b0);
    load("lw3000", 32'h3000, OP_W, 32'h0, 1'b1);
    load("lh5", 32'h5, OP_H, 32'h0, 1'b1);
    load("lw5", 32'h5, OP_W, 32'h0, 1'b1);
    load("lb5", 32'h5, OP_B, 32'hFFFF_FFA5, 1'b0);

    // 5: read-during-write sees old data until the edge
    store("sw40", 32'h40, OP_W, 32'h1111_1111, 1'b0);
    @(negedge clk);
    addr      = 32'h40;
    mem_op    = OP_W;
    wdata     = 32'hDEAD_BEEF;
    mem_write = 1'b1;
    sb_q.push_back('{"rdw_pre", 1'b1, 32'h1111_1111, 1'b0});
    #1;
    compare();
    @(posedge clk);
    #1;
    sb_q.push_back('{"rdw_post", 1'b1, 32'hDEAD_BEEF, 1'b0});
    compare();
    mem_write = 1'b0;

    // 6: reserved op, with and without mem_write
    load("rsv_ld", 32'h40, OP_RS, 32'h0, 1'b1);
    @(posedge clk);
    load("lw40a", 32'h40, OP_W, 32'hDEAD_BEEF, 1'b0);
    store("rsv_st", 32'h40, OP_RS, 32'h0, 1'b1);
    load("lw40b", 32'h40, OP_W, 32'hDEAD_BEEF, 1'b0);

    total++;
    assert (sb_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_left got=%0d exp=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
